// File: rtl/wm8731_cfg_seq_pkg.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_seq_pkg
// Shared definitions for the WM8731 configuration sequencer: default
// parameter values, codec register addresses, initialisation data values,
// FSM state encoding and a helper that packs one table entry.
// No ports (package).
// -----------------------------------------------------------------------------
package wm8731_cfg_seq_pkg;

    localparam logic [7:0] DEV_ADDR_DEF    = 8'h34;
    localparam int         NUM_REGS        = 11;
    localparam int         IDX_W           = 4;
    localparam int         TMR_W           = 8;
    localparam int         POWERUP_CYC_DEF = 200;
    localparam int         GAP_CYC_DEF     = 4;
    localparam int         TIMEOUT_CYC_DEF = 64;
    localparam int         MAX_RETRY_DEF   = 3;
    localparam int         AUTO_START_DEF  = 1;

    // Codec register addresses (7 bits)
    localparam logic [6:0] R0  = 7'h00;   // left line in
    localparam logic [6:0] R1  = 7'h01;   // right line in
    localparam logic [6:0] R2  = 7'h02;   // left headphone out
    localparam logic [6:0] R3  = 7'h03;   // right headphone out
    localparam logic [6:0] R4  = 7'h04;   // analogue path
    localparam logic [6:0] R5  = 7'h05;   // digital path
    localparam logic [6:0] R6  = 7'h06;   // power down
    localparam logic [6:0] R7  = 7'h07;   // digital interface format
    localparam logic [6:0] R8  = 7'h08;   // sampling control
    localparam logic [6:0] R9  = 7'h09;   // active control
    localparam logic [6:0] R15 = 7'h0F;   // reset

    // Initialisation data (9 bits)
    localparam logic [8:0] D_RESET  = 9'h000;
    localparam logic [8:0] D_LLIN   = 9'h017;
    localparam logic [8:0] D_RLIN   = 9'h017;
    localparam logic [8:0] D_LHP    = 9'h079;
    localparam logic [8:0] D_RHP    = 9'h079;
    localparam logic [8:0] D_APATH  = 9'h012;
    localparam logic [8:0] D_DPATH  = 9'h000;
    localparam logic [8:0] D_PWR    = 9'h000;
    localparam logic [8:0] D_IFACE  = 9'h002;
    localparam logic [8:0] D_SRATE  = 9'h000;
    localparam logic [8:0] D_ACTIVE = 9'h001;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_XFER     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } cfg_state_t;

    function automatic logic [15:0] cfg_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_rom
// Combinational initialisation table: index -> {reg_addr[6:0], reg_data[8:0]}.
// Entry 0 resets the codec, entry 10 activates it. Out-of-range -> 16'h0.
// Ports:
//   index  in   4   table index
//   word   out  16  {reg_addr, reg_data}
// -----------------------------------------------------------------------------
module wm8731_cfg_rom
    import wm8731_cfg_seq_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    always_comb begin
        word = 16'h0;
        case (index)
            4'd0:    word = cfg_word(R15, D_RESET);
            4'd1:    word = cfg_word(R0,  D_LLIN);
            4'd2:    word = cfg_word(R1,  D_RLIN);
            4'd3:    word = cfg_word(R2,  D_LHP);
            4'd4:    word = cfg_word(R3,  D_RHP);
            4'd5:    word = cfg_word(R4,  D_APATH);
            4'd6:    word = cfg_word(R5,  D_DPATH);
            4'd7:    word = cfg_word(R6,  D_PWR);
            4'd8:    word = cfg_word(R7,  D_IFACE);
            4'd9:    word = cfg_word(R8,  D_SRATE);
            4'd10:   word = cfg_word(R9,  D_ACTIVE);
            default: word = 16'h0;
        endcase
    end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_seq
// WM8731 register-initialisation sequencer feeding the i2c_com bit writer.
// Walks the 11-entry table, presents {DEV_ADDR, reg_addr, reg_data}, holds
// start until tr_end, checks ack, retries NAKs, reports done / error.
// Ports:
//   clock_i2c  in   1   I2C control clock (20 kHz), rising edge
//   reset_n    in   1   asynchronous active-low reset
//   cfg_start  in   1   (re)configuration request, level, IDLE/DONE/ERR only
//   tr_end     in   1   transfer finished (from i2c_com)
//   ack        in   1   0 = all bytes ACKed, 1 = NAK (from i2c_com)
//   start      out  1   transfer request, high for the whole transfer
//   i2c_data   out  24  word to send, stable while start=1
//   cfg_busy   out  1   sequence in progress
//   cfg_done   out  1   all entries written, sticky until next run
//   cfg_err    out  1   an entry failed all attempts, sticky until next run
//   reg_index  out  4   current table index
//
// state    | meaning
// PWR_WAIT | codec power-up wait after reset
// IDLE     | waiting for cfg_start
// LOAD     | i2c_data holds the next word, start still low
// XFER     | start high, waiting for tr_end or timeout
// CHECK    | evaluate ack, advance index or retry
// GAP      | start low so i2c_com can re-arm
// DONE     | table written
// ERR      | retries exhausted, reg_index points at failing entry
// -----------------------------------------------------------------------------
module wm8731_cfg_seq
    import wm8731_cfg_seq_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = DEV_ADDR_DEF,
    parameter int         POWERUP_CYC = POWERUP_CYC_DEF,
    parameter int         GAP_CYC     = GAP_CYC_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int         MAX_RETRY   = MAX_RETRY_DEF,
    parameter int         AUTO_START  = AUTO_START_DEF
)
(
    input  logic        clock_i2c,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic        tr_end,
    input  logic        ack,
    output logic        start,
    output logic [23:0] i2c_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  reg_index
);

    cfg_state_t       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [1:0]       retry, retry_nxt;
    logic             nak_q, nak_nxt;
    logic [15:0]      rom_word;

    // ROM is addressed with the next index so the word can be registered on
    // entry to LOAD, giving one cycle of data set-up ahead of start.
    wm8731_cfg_rom u_rom (
        .index (idx_nxt),
        .word  (rom_word)
    );

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        idx_nxt   = reg_index;
        retry_nxt = retry;
        nak_nxt   = nak_q;
        case (state)
            ST_PWR_WAIT: begin
                if (tmr == '0)
                    state_nxt = (AUTO_START != 0) ? ST_LOAD : ST_IDLE;
                else
                    tmr_nxt = tmr - 1'b1;
            end
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (cfg_start) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_XFER;
                tmr_nxt   = TMR_W'(TIMEOUT_CYC - 1);
            end
            ST_XFER: begin
                // Only the first tr_end cycle is used; a missing tr_end is a NAK.
                if (tr_end) begin
                    nak_nxt   = ack;
                    state_nxt = ST_CHECK;
                end else if (tmr == '0) begin
                    nak_nxt   = 1'b1;
                    state_nxt = ST_CHECK;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            ST_CHECK: begin
                if (!nak_q) begin
                    retry_nxt = '0;
                    idx_nxt   = reg_index + 1'b1;
                    if (reg_index == IDX_W'(NUM_REGS - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_GAP;
                        tmr_nxt   = TMR_W'(GAP_CYC - 1);
                    end
                end else if (retry < 2'(MAX_RETRY)) begin
                    retry_nxt = retry + 1'b1;
                    state_nxt = ST_GAP;
                    tmr_nxt   = TMR_W'(GAP_CYC - 1);
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_GAP: begin
                if (tmr == '0)
                    state_nxt = ST_LOAD;
                else
                    tmr_nxt = tmr - 1'b1;
            end
            default: state_nxt = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clock_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_PWR_WAIT;
            tmr       <= TMR_W'(POWERUP_CYC - 1);
            reg_index <= '0;
            retry     <= '0;
            nak_q     <= 1'b0;
            start     <= 1'b0;
            i2c_data  <= 24'h0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            reg_index <= idx_nxt;
            retry     <= retry_nxt;
            nak_q     <= nak_nxt;
            // Outputs are registered from the next state so they are glitch
            // free and line up exactly with the state they describe.
            start     <= (state_nxt == ST_XFER);
            cfg_busy  <= (state_nxt inside {ST_LOAD, ST_XFER, ST_CHECK, ST_GAP});
            cfg_done  <= (state_nxt == ST_DONE);
            cfg_err   <= (state_nxt == ST_ERR);
            if (state_nxt == ST_LOAD)
                i2c_data <= {DEV_ADDR, rom_word};
        end
    end

endmodule
